// File: rtl/adc_responder.sv
// SPI responder emulating an LTC2308-style 8-channel 12-bit ADC for loopback and bring-up.
// Serial inputs are synchronised into CLOCK; all actions happen 3 CLOCK after a pin edge.
`timescale 1ns/1ps
module adc_responder #(
  parameter int DATA_W      = 12,
  parameter int CFG_W       = 6,
  parameter int CONV_CYCLES = 80,
  parameter int CNT_W       = 16
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              ADC_SCLK,
  input  logic              ADC_CS_N,
  input  logic              ADC_DIN,
  output logic              ADC_DOUT,
  input  logic [DATA_W-1:0] CH0,
  input  logic [DATA_W-1:0] CH1,
  input  logic [DATA_W-1:0] CH2,
  input  logic [DATA_W-1:0] CH3,
  input  logic [DATA_W-1:0] CH4,
  input  logic [DATA_W-1:0] CH5,
  input  logic [DATA_W-1:0] CH6,
  input  logic [DATA_W-1:0] CH7,
  output logic [CFG_W-1:0]  CFG,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR,
  output logic              CONV_ERR,
  output logic [CNT_W-1:0]  FRAME_CNT
);

  localparam int CONV_W = $clog2(CONV_CYCLES + 1);
  localparam logic [CFG_W-1:0] CFG_RST = CFG_W'(6'b100010);

  typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_t;

  state_t             state;
  logic [2:0]         sclk_q;
  logic [2:0]         cs_q;
  logic [1:0]         din_q;
  logic [CONV_W-1:0]  cnt;
  logic [DATA_W-1:0]  sr;
  logic [CFG_W-1:0]   cfg_sr;
  logic [3:0]         rise_cnt;
  logic [2:0]         sel;
  logic [DATA_W-1:0]  chan_word;
  logic               sclk_rise, sclk_fall, cs_rise, cs_fall, din;

  // Synchroniser chains carry no reset: they simply track the pins.
  always_ff @(posedge CLOCK) begin
    sclk_q <= {sclk_q[1:0], ADC_SCLK};
    cs_q   <= {cs_q[1:0], ADC_CS_N};
    din_q  <= {din_q[0], ADC_DIN};
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign din       = din_q[1];

  // Channel number is {S1, S0, O/S}.
  assign sel = {CFG[3], CFG[2], CFG[4]};

  always_comb begin
    chan_word = CH0;
    case (sel)
      3'd0: chan_word = CH0;
      3'd1: chan_word = CH1;
      3'd2: chan_word = CH2;
      3'd3: chan_word = CH3;
      3'd4: chan_word = CH4;
      3'd5: chan_word = CH5;
      3'd6: chan_word = CH6;
      3'd7: chan_word = CH7;
      default: chan_word = CH0;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      ADC_DOUT   <= 1'b0;
      CFG        <= CFG_RST;
      FRAME_CNT  <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      CONV_ERR   <= 1'b0;
      cnt        <= '0;
      sr         <= '0;
      cfg_sr     <= '0;
      rise_cnt   <= '0;
    end else begin
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      CONV_ERR   <= 1'b0;
      case (state)
        IDLE: begin
          ADC_DOUT <= 1'b0;
          if (cs_rise) begin
            cnt   <= CONV_W'(CONV_CYCLES - 1);
            state <= CONVERT;
          end
        end
        CONVERT: begin
          if (cs_fall) begin
            CONV_ERR <= 1'b1;
            sr       <= '0;
            ADC_DOUT <= 1'b0;
            rise_cnt <= '0;
            state    <= SHIFT;
          end else if (cnt == '0) begin
            sr    <= chan_word;
            state <= READY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        READY: begin
          if (cs_rise) begin
            cnt   <= CONV_W'(CONV_CYCLES - 1);
            state <= CONVERT;
          end else if (cs_fall) begin
            ADC_DOUT <= sr[DATA_W-1];
            rise_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // CS_N rising wins over any SCLK edge seen in the same cycle.
          if (cs_rise) begin
            FRAME_DONE <= 1'b1;
            FRAME_CNT  <= FRAME_CNT + 1'b1;
            if (rise_cnt >= 4'(CFG_W)) CFG <= cfg_sr;
            if (rise_cnt != 4'(DATA_W)) FRAME_ERR <= 1'b1;
            ADC_DOUT   <= 1'b0;
            rise_cnt   <= '0;
            cnt        <= CONV_W'(CONV_CYCLES - 1);
            state      <= CONVERT;
          end else begin
            if (sclk_rise) begin
              if (rise_cnt < 4'(CFG_W)) cfg_sr <= {cfg_sr[CFG_W-2:0], din};
              if (rise_cnt != 4'hF) rise_cnt <= rise_cnt + 1'b1;
            end
            if (sclk_fall) begin
              sr       <= {sr[DATA_W-2:0], 1'b0};
              ADC_DOUT <= sr[DATA_W-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: transaction-level model of frames, configs and counters,
// a per-cycle compare process, and literal expectations pinning the model.
`timescale 1ns/1ps
module tb_adc_responder;

  localparam int CONV_CYCLES = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        din = 1'b0;
  logic [11:0] ch [8];

  logic        dout, done, ferr, cerr;
  logic [5:0]  cfg;
  logic [15:0] fcnt;
  logic        dout4, done4, ferr4, cerr4;
  logic [5:0]  cfg4;
  logic [3:0]  fcnt4;

  always #5 clk = ~clk;

  adc_responder dut (
    .CLOCK(clk), .RESET_N(rst_n), .ADC_SCLK(sclk), .ADC_CS_N(cs_n), .ADC_DIN(din),
    .ADC_DOUT(dout),
    .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
    .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
    .CFG(cfg), .FRAME_DONE(done), .FRAME_ERR(ferr), .CONV_ERR(cerr), .FRAME_CNT(fcnt)
  );

  // Narrow frame counter so wrap-around is reachable in a short run.
  adc_responder #(.CNT_W(4)) dut4 (
    .CLOCK(clk), .RESET_N(rst_n), .ADC_SCLK(sclk), .ADC_CS_N(cs_n), .ADC_DIN(din),
    .ADC_DOUT(dout4),
    .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
    .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
    .CFG(cfg4), .FRAME_DONE(done4), .FRAME_ERR(ferr4), .CONV_ERR(cerr4), .FRAME_CNT(fcnt4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state
  logic [5:0]  m_cfg;
  int          m_cnt;
  logic [11:0] m_word;
  bit          chk_en = 1'b0;
  int          n_done = 0, n_ferr = 0, n_cerr = 0;
  logic        prev_done = 1'b0;

  function automatic int chan_of(input logic [5:0] c);
    return int'({c[3], c[2], c[4]});
  endfunction

  always @(negedge clk) begin
    if (done) n_done++;
    if (ferr) n_ferr++;
    if (cerr) n_cerr++;
    if (chk_en) begin
      chk("cfg", 32'(cfg), 32'(m_cfg));
      chk("frame_cnt", 32'(fcnt), 32'(m_cnt & 16'hFFFF));
      chk("frame_cnt4", 32'(fcnt4), 32'(m_cnt & 15));
      chk("dout_between_frames", 32'(dout), 32'd0);
      chk("done_width", 32'(done & prev_done), 32'd0);
    end
    prev_done = done;
  end

  task automatic run_frame(input logic [5:0] c, input int nrise, input int conv_wait,
                           input bit poke, output logic [11:0] rd);
    logic [11:0] exp_rd, mask;
    bit exp_cerr;
    repeat (conv_wait) @(negedge clk);
    if (poke) for (int i = 0; i < 8; i++) ch[i] = ~ch[i];
    exp_cerr = conv_wait < CONV_CYCLES;
    n_done = 0; n_ferr = 0; n_cerr = 0;
    rd = '0;
    chk_en = 1'b0;
    cs_n = 1'b0;
    din = c[5];
    repeat (4) @(negedge clk);
    for (int k = 0; k < nrise; k++) begin
      if (k < 12) rd[11-k] = dout;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      din = (k + 1 < 6) ? c[5-(k+1)] : 1'b0;
      repeat (4) @(negedge clk);
    end
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    if (poke) for (int i = 0; i < 8; i++) ch[i] = ~ch[i];
    exp_rd = exp_cerr ? 12'h000 : m_word;
    mask = 12'hFFF;
    if (nrise < 12) mask = ~(mask >> nrise);
    chk("read_word", 32'(rd & mask), 32'(exp_rd & mask));
    chk("frame_done_pulses", 32'(n_done), 32'd1);
    chk("frame_err_pulses", 32'(n_ferr), 32'(nrise != 12));
    chk("conv_err_pulses", 32'(n_cerr), 32'(exp_cerr));
    if (nrise >= 6) m_cfg = c;
    m_cnt++;
    m_word = ch[chan_of(m_cfg)];
    chk_en = 1'b1;
  endtask

  initial begin
    logic [11:0] rd;
    logic [5:0]  c;
    for (int i = 0; i < 8; i++) ch[i] = 12'(12'h100 * i + 12'h0A5);

    repeat (5) @(negedge clk);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_cfg", 32'(cfg), 32'h22);
    chk("reset_cnt", 32'(fcnt), 32'd0);
    chk("reset_done", 32'(done | ferr | cerr), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_done = 0;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_fall_rise_no_done", 32'(n_done), 32'd0);
    m_cfg = 6'b100010; m_cnt = 0; m_word = ch[0];
    chk_en = 1'b1;

    run_frame(6'b100010, 12, 100, 1'b0, rd);
    chk("f1_word_lit", 32'(rd), 32'h0A5);
    chk("f1_cfg_lit", 32'(cfg), 32'h22);
    chk("f1_cnt_lit", 32'(fcnt), 32'd1);
    run_frame(6'b110010, 12, 100, 1'b1, rd);
    chk("f2_ch_held_lit", 32'(rd), 32'h0A5);
    run_frame(6'b111110, 12, 100, 1'b0, rd);
    chk("f3_ch1_lit", 32'(rd), 32'h1A5);
    run_frame(6'b100010, 12, 100, 1'b0, rd);
    chk("f4_ch7_lit", 32'(rd), 32'h7A5);
    run_frame(6'b100010, 12, 40, 1'b0, rd);
    chk("f5_conv_err_word_lit", 32'(rd), 32'h000);
    chk("f5_cnt_lit", 32'(fcnt), 32'd5);
    run_frame(6'b110010, 4, 100, 1'b0, rd);
    chk("f6_short_cfg_lit", 32'(cfg), 32'h22);
    run_frame(6'b100010, 12, 100, 1'b0, rd);
    chk("f7_clean_lit", 32'(rd), 32'h0A5);
    for (int i = 0; i < 10; i++) begin
      c = {1'b1, i[0], i[2], i[1], 2'b10};
      run_frame(c, 12, 100, 1'b0, rd);
    end
    chk("wrap4_lit", 32'(fcnt4), 32'd1);
    chk("cnt17_lit", 32'(fcnt), 32'd17);

    // Reset in the middle of a frame
    repeat (100) @(negedge clk);
    chk_en = 1'b0;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_dout", 32'(dout), 32'd0);
    chk("midreset_cfg", 32'(cfg), 32'h22);
    chk("midreset_cnt", 32'(fcnt), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_done = 0;
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midreset_no_done", 32'(n_done), 32'd0);
    m_cfg = 6'b100010; m_cnt = 0; m_word = ch[0];
    chk_en = 1'b1;
    run_frame(6'b100010, 12, 100, 1'b0, rd);
    chk("post_reset_word_lit", 32'(rd), 32'h0A5);
    chk("post_reset_cnt_lit", 32'(fcnt), 32'd1);

    chk_en = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
